// File: rtl/ucom_timer.sv
// Multi-channel interval timer: per channel, a PW-bit prescaler feeds a BW-bit down-counter
// that sets a TM flag on expiry, in one-shot or auto-reload mode.
module ucom_timer #(
  parameter int CH = 2,
  parameter int PW = 6,
  parameter int BW = 6
) (
  input  logic             clk,
  input  logic             _RESET,
  input  logic             tick,
  input  logic [CH-1:0]    load,
  input  logic [CH*BW-1:0] load_val,
  input  logic [CH-1:0]    reload,
  input  logic [CH-1:0]    run,
  input  logic [CH-1:0]    tm_clr,
  input  logic [CH-1:0]    ien,
  output logic [CH-1:0]    tm,
  output logic             irq,
  output logic [CH*BW-1:0] bcount
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state  [CH];
  logic [PW-1:0] pcount [CH];
  logic [BW-1:0] bcnt   [CH];
  logic [BW-1:0] rval   [CH];
  logic [CH-1:0] mode;

  logic [CH-1:0] qual;
  logic [CH-1:0] wrap;
  logic [CH-1:0] expire;

  always_comb begin
    qual   = '0;
    wrap   = '0;
    expire = '0;
    for (int i = 0; i < CH; i++) begin
      qual[i]   = (state[i] == RUN) && run[i] && tick && !load[i];
      wrap[i]   = qual[i] && (&pcount[i]);
      expire[i] = wrap[i] && (bcnt[i] == '0);
    end
  end

  // Load beats expiry, and expiry beats tm_clr so a coincident event is never lost.
  always_ff @(posedge clk or negedge _RESET) begin
    if (!_RESET) begin
      for (int i = 0; i < CH; i++) begin
        state[i]  <= IDLE;
        pcount[i] <= '0;
        bcnt[i]   <= '0;
        rval[i]   <= '0;
      end
      mode <= '0;
      tm   <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (load[i]) begin
          pcount[i] <= '0;
          bcnt[i]   <= load_val[i*BW +: BW];
          rval[i]   <= load_val[i*BW +: BW];
          mode[i]   <= reload[i];
          tm[i]     <= 1'b0;
          state[i]  <= RUN;
        end else begin
          if (qual[i]) begin
            pcount[i] <= pcount[i] + PW'(1);
          end
          if (wrap[i]) begin
            if (!expire[i]) begin
              bcnt[i] <= bcnt[i] - BW'(1);
            end else if (mode[i]) begin
              bcnt[i] <= rval[i];
            end else begin
              state[i] <= IDLE;
            end
          end
          if (expire[i]) begin
            tm[i] <= 1'b1;
          end else if (tm_clr[i]) begin
            tm[i] <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_bcount
    assign bcount[g*BW +: BW] = bcnt[g];
  end

  assign irq = |(tm & ien);

endmodule

// File: doc/ucom_timer.md
# ucom_timer

Multi-channel programmable interval timer for the uCOM-43 MCU family, generalising the single STM/TTM timer into CH independent channels. Each channel chains a PW-bit prescaler with a BW-bit binary down-counter. Each channel can run one-shot or auto-reload, and has its own expiry flag (TM), clear and interrupt enable. The block sits beside the MCU core: the core drives `tick` from its clock-enable, loads channels on STM, and samples `tm`/`irq` for TTM and interrupt entry.

## Interface
- `CH`, default 2: number of timer channels (1..8).
- `PW`, default 6: prescaler width in bits; one prescaler period is 2^PW qualifying ticks.
- `BW`, default 6: binary counter width in bits.

- `clk`  in  1  system clock.
- `_RESET`  in  1  asynchronous, active-low reset.
- `tick`  in  1  count enable; one qualifying tick per cycle when high.
- `load`  in  CH  per-channel load strobe.
- `load_val`  in  CH*BW  load value; channel i uses bits [i*BW +: BW].
- `reload`  in  CH  mode, sampled at load: 1 = auto-reload, 0 = one-shot.
- `run`  in  CH  0 pauses the channel and holds both counters.
- `tm_clr`  in  CH  clears the TM flag.
- `ien`  in  CH  interrupt enable mask.
- `tm`  out  CH  TM expiry flag per channel.
- `irq`  out  1  interrupt request, equal to OR over i of (tm[i] & ien[i]).
- `bcount`  out  CH*BW  live binary counter per channel.

## Operation
- Per-channel state: IDLE or RUN; registers `pcount[PW]`, `bcount[BW]`, `rval[BW]`, `mode`, `tm`.
- Reset (async, `_RESET`=0) puts every channel in IDLE with pcount=0, bcount=0, rval=0, mode=0, tm=0. Therefore `tm`=0 and `irq`=0.
- load[i]=1 (any state):
  - pcount←0, bcount←load_val_i, rval←load_val_i, mode←reload[i];
  - tm←0, state←RUN.
  - No counting occurs in the load cycle.
- Qualifying tick: state=RUN, run[i]=1, tick=1, load[i]=0. On each qualifying tick pcount increments, wrapping modulo 2^PW.
- When pcount is all-ones on a qualifying tick:
  - if bcount≠0: bcount←bcount−1.
  - if bcount=0 (expiry): tm←1.
    - One-shot: state←IDLE, bcount holds 0, pcount wraps to 0.
    - Auto-reload: bcount←rval, pcount←0, state stays RUN.
- Period after load of V is (V+1)·2^PW qualifying ticks, for V in 0..2^BW−1. V=0 gives 2^PW ticks.
- IDLE channels ignore tick and run; counters hold.
- tm_clr[i]=1 gives tm←0, unless an expiry happens in the same cycle (expiry wins, so no event is lost) or load is also asserted (load clears tm anyway).
- Priority per channel: reset > load > expiry > tm_clr > count.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-count aborts immediately. The channel does not restart until the next load.

## Timing
- All state updates on posedge clk except reset, which is asynchronous. Reset deassertion is synchronised externally.
- `tm` rises on the clock edge that samples the terminal qualifying tick, and is visible on the output after that edge.
- `irq` is combinational from registered `tm` and input `ien`: zero added latency, no glitch path from `tick`.
- `bcount` reflects the register: the new value is visible the cycle after load or decrement.
- A `load` one cycle after expiry restarts cleanly. A `load` in the same cycle as expiry suppresses that expiry, so tm stays 0.
- `run` low holds pcount and bcount exactly. Resuming continues from the held value, with no lost or extra tick.

## Test plan
- Reset: hold `_RESET`=0 with tick=1 and random inputs. Require tm=0, irq=0 and bcount=0 on all channels. After release, with no load, all of these stay 0 for 100 cycles.
- One-shot (PW=2, BW=4), load V=3, reload=0, tick=1 continuously:
  - tm[0] is 0 after 15 qualifying ticks and rises exactly after the 16th;
  - bcount sequence is 3,2,1,0 at 4-tick steps;
  - channel goes IDLE, bcount holds 0, tm stays 1.
- Auto-reload (PW=2), V=1: tm pulses set every 8 ticks. Clear with tm_clr after each set. bcount goes back to 1 after each expiry. Check 4 consecutive periods.
- Pause: with tick toggling 50% and run[1] low for 10 cycles mid-count, expiry is delayed by exactly the number of suppressed ticks.
- Collisions:
  - tm_clr in the same cycle as expiry leaves tm=1;
  - load in the same cycle as expiry leaves tm=0 and restarts at the new value.
- Interrupts: with CH=2, ien=2'b10 and both channels expired, irq=1. Clearing tm[1] drops irq to 0 even while tm[0]=1. Setting ien[0] raises irq in the same cycle.
